// File: rtl/sseg_pkg.sv
// rtl/sseg_pkg.sv - shared seven-segment types, glyph table and decoder
// Purpose: common definitions for the display drivers and the scan capture
// monitor. Patterns are active low, bit order {g,f,e,d,c,b,a}.
// Contents: sseg_t, SSEG_BLANK, SSEG_GLYPHS[16], sseg_to_hex().
package sseg_pkg;

    typedef logic [6:0] sseg_t;

    localparam sseg_t SSEG_BLANK = 7'h7F;

    // Index i holds the glyph of hex digit i.
    localparam sseg_t SSEG_GLYPHS [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Returns {valid, nibble}; unrecognised patterns (including blank) give 0.
    function automatic logic [4:0] sseg_to_hex(input sseg_t pattern);
        logic [4:0] result;
        result = 5'b0;
        for (int i = 0; i < 16; i++) begin
            if (pattern == SSEG_GLYPHS[i]) begin
                result = {1'b1, 4'(i)};
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/sseg_stale_timer.sv
// rtl/sseg_stale_timer.sv - per-digit saturating no-capture timer
// Purpose: counts cycles since the last capture of one digit and flags the
// digit stale once the count saturates at TIMEOUT_CYCLES.
// Ports:
//   clk    system clock
//   rst_n  synchronous reset, active low
//   clear  capture of this digit this cycle (wins over saturation)
//   stale  registered, high while the count sits at TIMEOUT_CYCLES
module sseg_stale_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic stale
);

    localparam int unsigned W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES);

    logic [W-1:0] count_q;
    logic [W-1:0] count_next;

    always_comb begin
        count_next = count_q;
        if (clear) begin
            count_next = '0;
        end else if (count_q != LIMIT) begin
            count_next = count_q + W'(1);
        end
    end

    // stale follows the next count so it rises on the saturating edge and
    // falls on the capturing edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
            stale   <= 1'b0;
        end else begin
            count_q <= count_next;
            stale   <= (count_next == LIMIT);
        end
    end

endmodule

// File: rtl/sseg_scan_capture.sv
// rtl/sseg_scan_capture.sv - scanned seven-segment bus capture and decode
// Purpose: samples a time-multiplexed anode/segment/dp bus, waits for each
// digit slot to settle, latches per-digit patterns, decodes them to hex,
// pulses on complete frames and flags digits that stop being refreshed.
// Ports:
//   clk_i          system clock
//   rst_ni         synchronous reset, active low
//   an_i[3:0]      anode selects, active low (an_i[k]=0 selects digit k)
//   sseg_i[6:0]    segments, active low, {g,f,e,d,c,b,a}
//   dp_i           decimal point, active low
//   digits_o[27:0] latched patterns, digit k at [7k+6:7k]
//   dps_o[3:0]     latched decimal points
//   hex_o[15:0]    decoded nibbles, digit k at [4k+3:4k]
//   hex_valid_o    digit k holds a recognised glyph
//   frame_valid_o  one-cycle pulse when all four digits have been captured
//   stale_o        digit k has gone TIMEOUT_CYCLES without a capture
module sseg_scan_capture
    import sseg_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [3:0]  an_i,
    input  logic [6:0]  sseg_i,
    input  logic        dp_i,
    output logic [27:0] digits_o,
    output logic [3:0]  dps_o,
    output logic [15:0] hex_o,
    output logic [3:0]  hex_valid_o,
    output logic        frame_valid_o,
    output logic [3:0]  stale_o
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_SETTLE   = 2'd1;
    localparam logic [1:0] ST_CAPTURED = 2'd2;

    localparam logic [7:0]  SETTLE_LIMIT = 8'(SETTLE_CYCLES);
    localparam logic [11:0] BLANK_SAMPLE = {4'hF, SSEG_BLANK, 1'b1};

    logic [3:0]  an_r;
    sseg_t       seg_r;
    logic        dp_r;
    logic [11:0] prev_r;
    logic [1:0]  state_q;
    logic [1:0]  state_next;
    logic [7:0]  count_q;
    logic [7:0]  count_next;
    logic [3:0]  seen_q;
    logic [11:0] sample;
    logic        changed;
    logic [3:0]  sel_low;
    logic        sel_valid;
    logic [1:0]  sel_idx;
    logic        capture;
    logic [3:0]  capture_mask;
    logic [3:0]  seen_or;
    logic [4:0]  decoded;

    assign sample  = {an_r, seg_r, dp_r};
    assign changed = (sample != prev_r);

    // Exactly one anode low: nonzero and a power of two after inversion.
    assign sel_low   = ~an_r;
    assign sel_valid = (sel_low != 4'd0) && ((sel_low & (sel_low - 4'd1)) == 4'd0);

    always_comb begin
        sel_idx = 2'd0;
        case (an_r)
            4'b1110: sel_idx = 2'd0;
            4'b1101: sel_idx = 2'd1;
            4'b1011: sel_idx = 2'd2;
            4'b0111: sel_idx = 2'd3;
            default: sel_idx = 2'd0;
        endcase
    end

    always_comb begin
        state_next = state_q;
        count_next = count_q;
        capture    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sel_valid) begin
                    state_next = ST_SETTLE;
                    count_next = 8'd1;
                end
            end
            ST_SETTLE, ST_CAPTURED: begin
                if (changed) begin
                    if (sel_valid) begin
                        state_next = ST_SETTLE;
                        count_next = 8'd1;
                    end else begin
                        state_next = ST_IDLE;
                        count_next = 8'd0;
                    end
                end else if (state_q == ST_SETTLE) begin
                    count_next = count_q + 8'd1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                count_next = 8'd0;
            end
        endcase
        // Capture on the edge where the count reaches the limit, so a
        // limit of 1 captures on the first registered sample.
        if (state_next == ST_SETTLE && count_next == SETTLE_LIMIT) begin
            capture    = 1'b1;
            state_next = ST_CAPTURED;
        end
    end

    assign capture_mask = capture ? (4'b0001 << sel_idx) : 4'b0000;
    assign seen_or      = seen_q | capture_mask;
    assign decoded      = sseg_to_hex(seg_r);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            an_r          <= 4'hF;
            seg_r         <= SSEG_BLANK;
            dp_r          <= 1'b1;
            prev_r        <= BLANK_SAMPLE;
            state_q       <= ST_IDLE;
            count_q       <= 8'd0;
            seen_q        <= 4'd0;
            digits_o      <= {4{SSEG_BLANK}};
            dps_o         <= 4'hF;
            hex_o         <= 16'd0;
            hex_valid_o   <= 4'd0;
            frame_valid_o <= 1'b0;
        end else begin
            an_r          <= an_i;
            seg_r         <= sseg_i;
            dp_r          <= dp_i;
            prev_r        <= sample;
            state_q       <= state_next;
            count_q       <= count_next;
            frame_valid_o <= 1'b0;
            if (capture) begin
                for (int k = 0; k < 4; k++) begin
                    if (capture_mask[k]) begin
                        digits_o[7*k +: 7] <= seg_r;
                        dps_o[k]           <= dp_r;
                        hex_o[4*k +: 4]    <= decoded[3:0];
                        hex_valid_o[k]     <= decoded[4];
                    end
                end
                // The completing capture starts the next frame empty.
                if (seen_or == 4'hF) begin
                    frame_valid_o <= 1'b1;
                    seen_q        <= 4'd0;
                end else begin
                    seen_q <= seen_or;
                end
            end
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_timer
        sseg_stale_timer #(
            .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
        ) u_timer (
            .clk  (clk_i),
            .rst_n(rst_ni),
            .clear(capture_mask[g]),
            .stale(stale_o[g])
        );
    end

endmodule

// File: tb/tb_sseg_scan_capture.sv
// tb/tb_sseg_scan_capture.sv - self-checking bench for sseg_scan_capture
module tb_sseg_scan_capture;

    localparam int S = 4;
    localparam int T = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  an = 4'hF;
    logic [6:0]  seg = 7'h7F;
    logic        dp = 1'b1;
    logic [27:0] digits_o;
    logic [3:0]  dps_o;
    logic [15:0] hex_o;
    logic [3:0]  hex_valid_o;
    logic        frame_valid_o;
    logic [3:0]  stale_o;
    logic [56:0] got;

    always #5 clk = ~clk;

    sseg_scan_capture #(
        .SETTLE_CYCLES (S),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .an_i         (an),
        .sseg_i       (seg),
        .dp_i         (dp),
        .digits_o     (digits_o),
        .dps_o        (dps_o),
        .hex_o        (hex_o),
        .hex_valid_o  (hex_valid_o),
        .frame_valid_o(frame_valid_o),
        .stale_o      (stale_o)
    );

    assign got = {digits_o, dps_o, hex_o, hex_valid_o, frame_valid_o, stale_o};

    int n_checks = 0;
    int n_errors = 0;
    int frames_seen = 0;

    logic [6:0] glyphs [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model: a capture happens when the last S sampled bus values
    // are identical with a one-hot-low select; staleness is elapsed edges.
    logic [6:0]  m_dig [4];
    logic        m_dp [4];
    int          m_last [4];
    logic [3:0]  m_seen;
    logic        m_frame;
    logic [11:0] m_prev;
    int          m_run;
    int          m_edge = 0;

    task automatic check(input string name, input logic [63:0] g, input logic [63:0] e);
        n_checks++;
        if (g !== e) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, g, e);
        end
    endtask

    function automatic logic [4:0] ref_hex(input logic [6:0] p);
        case (p)
            7'h40: return 5'h10;  7'h79: return 5'h11;  7'h24: return 5'h12;  7'h30: return 5'h13;
            7'h19: return 5'h14;  7'h12: return 5'h15;  7'h02: return 5'h16;  7'h78: return 5'h17;
            7'h00: return 5'h18;  7'h10: return 5'h19;  7'h08: return 5'h1A;  7'h03: return 5'h1B;
            7'h46: return 5'h1C;  7'h21: return 5'h1D;  7'h06: return 5'h1E;  7'h0E: return 5'h1F;
            default: return 5'h00;
        endcase
    endfunction

    function automatic int low_count(input logic [3:0] a);
        int c = 0;
        for (int i = 0; i < 4; i++) if (!a[i]) c++;
        return c;
    endfunction

    function automatic int low_pos(input logic [3:0] a);
        for (int i = 0; i < 4; i++) if (!a[i]) return i;
        return 0;
    endfunction

    task automatic model_edge();
        logic [11:0] smp;
        int k;
        m_edge++;
        m_frame = 1'b0;
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                m_dig[i] = 7'h7F; m_dp[i] = 1'b1; m_last[i] = m_edge;
            end
            m_seen = 4'd0;
            m_prev = 12'hFFF;
            m_run  = 1;
        end else begin
            if (low_count(m_prev[11:8]) == 1 && m_run == S) begin
                k = low_pos(m_prev[11:8]);
                m_dig[k] = m_prev[7:1];
                m_dp[k] = m_prev[0];
                m_last[k] = m_edge;
                m_seen[k] = 1'b1;
                if (m_seen == 4'hF) begin
                    m_frame = 1'b1;
                    m_seen  = 4'd0;
                end
            end
            smp = {an, seg, dp};
            if (smp == m_prev) begin
                if (m_run < 1000) m_run++;
            end else begin
                m_run = 1;
            end
            m_prev = smp;
        end
    endtask

    function automatic logic [56:0] model_out();
        logic [27:0] d; logic [3:0] p; logic [15:0] h; logic [3:0] v; logic [3:0] st;
        logic [4:0] x;
        for (int k = 0; k < 4; k++) begin
            d[7*k +: 7] = m_dig[k];
            p[k] = m_dp[k];
            x = ref_hex(m_dig[k]);
            h[4*k +: 4] = x[3:0];
            v[k] = x[4];
            st[k] = (m_edge - m_last[k]) >= T;
        end
        return {d, p, h, v, m_frame, st};
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        if (frame_valid_o) frames_seen++;
        check("model", 64'(got), 64'(model_out()));
    endtask

    task automatic hold(input logic [3:0] a, input logic [6:0] s, input logic d, input int n);
        an = a; seg = s; dp = d;
        repeat (n) step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; an = 4'hF; seg = 7'h7F; dp = 1'b1;
        step();
        step();
        check("reset", 64'(got), 64'({28'hFFFFFFF, 4'hF, 16'h0, 4'h0, 1'b0, 4'h0}));
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        dp;
        int          cycles;
        logic [15:0] hex;
        logic [3:0]  hv;
        int          frames;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int r;
        vecs[0] = '{4'hE, 7'h40, 1'b0, 8,  16'h0000, 4'h1, 0};
        vecs[1] = '{4'hD, 7'h79, 1'b1, 8,  16'h0010, 4'h3, 0};
        vecs[2] = '{4'hB, 7'h24, 1'b0, 8,  16'h0210, 4'h7, 0};
        vecs[3] = '{4'h7, 7'h30, 1'b1, 8,  16'h3210, 4'hF, 1};
        vecs[4] = '{4'hD, 7'h00, 1'b1, 8,  16'h3280, 4'hF, 0};
        vecs[5] = '{4'hC, 7'h12, 1'b0, 20, 16'h3280, 4'hF, 0};
        vecs[6] = '{4'hF, 7'h00, 1'b0, 20, 16'h3280, 4'hF, 0};
        vecs[7] = '{4'h7, 7'h7F, 1'b1, 8,  16'h0280, 4'h7, 0};
        vecs[8] = '{4'hB, 7'h0E, 1'b1, 8,  16'h0F80, 4'h7, 0};
        vecs[9] = '{4'hE, 7'h55, 1'b0, 8,  16'h0F80, 4'h6, 1};

        // Single digit hold: exact capture latency.
        do_reset();
        an = 4'hE; seg = 7'h24; dp = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            step();
            if (c == 4) check("lat_before", digits_o[6:0], 7'h7F);
            if (c == 5) check("lat_at", digits_o[6:0], 7'h24);
        end
        check("one_hex", hex_o, 16'h0002);
        check("one_hv", hex_valid_o, 4'h1);
        check("one_others", digits_o[27:7], 21'h1FFFFF);

        // Directed scan, invalid selects, blank and unknown glyphs.
        for (int i = 0; i < 10; i++) begin
            frames_seen = 0;
            hold(vecs[i].an, vecs[i].seg, vecs[i].dp, vecs[i].cycles);
            check($sformatf("vec%0d_hex", i), hex_o, vecs[i].hex);
            check($sformatf("vec%0d_hv", i), hex_valid_o, vecs[i].hv);
            check($sformatf("vec%0d_frames", i), frames_seen, vecs[i].frames);
        end

        // Short segment glitch on a settled digit.
        hold(4'hD, 7'h79, 1'b1, 8);
        seg = 7'h00;
        for (int c = 0; c < 10; c++) begin
            if (c == 2) seg = 7'h79;
            step();
            check("glitch", digits_o[13:7], 7'h79);
        end

        // Stale detection on an undriven digit, then recovery.
        do_reset();
        for (int c = 1; c <= 100; c++) begin
            int d;
            d = ((c - 1) / 8) % 3;
            an = ~(4'b0001 << d); seg = glyphs[d]; dp = 1'b1;
            step();
            if (c == 63) check("stale_before", stale_o, 4'b0000);
            if (c == 64) check("stale_at", stale_o, 4'b1000);
        end
        an = 4'h7; seg = 7'h30;
        for (int c = 1; c <= 5; c++) begin
            step();
            if (c == 4) check("stale_held", stale_o[3], 1'b1);
            if (c == 5) check("stale_clear", stale_o[3], 1'b0);
        end

        // Reset while digit 2 is settling at count 3.
        do_reset();
        hold(4'hB, 7'h06, 1'b1, 4);
        rst_n = 1'b0;
        step();
        check("rst_mid", 64'(got), 64'({28'hFFFFFFF, 4'hF, 16'h0, 4'h0, 1'b0, 4'h0}));
        rst_n = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            step();
            if (c == 4) check("rst_resume_before", hex_valid_o[2], 1'b0);
            if (c == 5) check("rst_resume_at", hex_o[11:8], 4'hE);
        end

        // Randomized bus activity against the model.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
            end
            r = $urandom_range(0, 7);
            if (r < 4) an = ~(4'b0001 << r);
            else if (r == 4) an = 4'hF;
            else if (r == 5) an = 4'($urandom);
            seg = ($urandom_range(0, 3) != 0) ? glyphs[$urandom_range(0, 15)] : 7'($urandom);
            dp = 1'($urandom);
            repeat ($urandom_range(1, 10)) step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/sseg_scan_capture.md
Name: sseg_scan_capture

Overview:
- Receive-side counterpart of the time-multiplexed seven-segment driver.
- Samples the scanned anode/segment/dp bus, waits until each digit slot has settled, and latches the per-digit patterns.
- Decodes each latched pattern to a hex nibble, flags complete frames, and marks stale digits.
- Used as an on-chip display monitor and as the checker that display-producing blocks (heartbeat, counters) are verified against.

Parameters:
- SETTLE_CYCLES, 4: consecutive identical samples required before capture; legal range 1..255.
- TIMEOUT_CYCLES, 1_000_000: cycles without a capture after which a digit is declared stale; must be at least 1.

Ports:
- clk_i  input  1  system clock
- rst_ni  input  1  synchronous reset, active low
- an_i  input  4  anode selects, active low; an_i[k]=0 selects digit k
- sseg_i  input  7  segments, active low, bit order {g,f,e,d,c,b,a}
- dp_i  input  1  decimal point, active low
- digits_o  output  28  latched patterns; digit k occupies bits [7k+6:7k]
- dps_o  output  4  latched decimal points, one per digit
- hex_o  output  16  decoded nibbles; digit k occupies bits [4k+3:4k]
- hex_valid_o  output  4  bit k set when digit k holds a recognised hex glyph
- frame_valid_o  output  1  one-cycle pulse when all four digits have been captured since the last pulse
- stale_o  output  4  bit k set when digit k has gone TIMEOUT_CYCLES without a capture

Behaviour:
- Clock and reset:
  - Single clock domain; rst_ni sampled on posedge clk_i only.
  - Reset values: digits_o all 7'h7F (blank), dps_o 4'hF, hex_o 0, hex_valid_o 0, frame_valid_o 0, stale_o 0.
  - Reset also clears the seen mask, the settle counter and the stale timers.
- Input stage: an_i, sseg_i and dp_i are registered once into an_r, seg_r and dp_r. All further logic uses the registered values.
- Select validity: a select is valid only when an_r has exactly one zero bit. 4'hF (blanking) and multi-low patterns are invalid.
- FSM, three states:
  - IDLE: select is invalid. Go to SETTLE with count=1 when a valid select appears.
  - SETTLE: count consecutive cycles in which {an_r, seg_r, dp_r} equals the previous sample.
    - Any change with a valid select: restart at count=1.
    - Any change to an invalid select: go to IDLE.
    - When count reaches SETTLE_CYCLES: capture and go to CAPTURED.
  - CAPTURED: hold with no further capture. A change goes to SETTLE (count=1) or IDLE, using the same rules as SETTLE.
  - SETTLE_CYCLES=1 captures on the first registered sample of a new valid value.
- Capture latency: a new stable value presented before edge E0 appears on digits_o, dps_o, hex_o and hex_valid_o after edge E0+SETTLE_CYCLES.
- Capture of digit k:
  - digits_o[k] <= seg_r and dps_o[k] <= dp_r.
  - Decode against {g..a} active low: 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E (hex).
  - Match: hex_o[k] gets the value and hex_valid_o[k]=1. No match (including blank 7F): hex_o[k]=0 and hex_valid_o[k]=0.
  - dp_r does not affect the decode.
- Frame tracking:
  - A capture of digit k sets seen[k]; re-capturing a digit already seen is harmless.
  - When a capture makes seen==4'hF, frame_valid_o pulses high in the following cycle.
  - seen clears to 0 on that same edge, so the completing capture is not carried into the next frame.
- Stale timers, one per digit:
  - Each timer clears to 0 on a capture of its digit; otherwise it increments and saturates at TIMEOUT_CYCLES.
  - stale_o[k] = (timer_k == TIMEOUT_CYCLES), registered.
  - A capture and saturation in the same cycle resolve to capture, so stale_o[k] goes low.
  - After reset, a digit that is never driven goes stale TIMEOUT_CYCLES cycles after reset release.
- Reset mid-settle: the count is discarded and no capture occurs. Capture resumes SETTLE_CYCLES samples after reset release once inputs are stable.
- Glitch immunity: a segment glitch shorter than SETTLE_CYCLES never reaches the outputs.

Decomposition:
- Package sseg_pkg holds:
  - typedef sseg_t (logic [6:0]);
  - constant SSEG_BLANK = 7'h7F;
  - the 16-entry glyph table constant;
  - function sseg_to_hex returning {valid, nibble}, shared with the display drivers' testbenches.
- One sub-module, sseg_stale_timer: counter, saturate and clear on capture, parameterised by TIMEOUT_CYCLES, instantiated four times.

Test Plan (SETTLE_CYCLES=4, TIMEOUT_CYCLES=64):
1. Hold an_i=4'b1110, sseg_i=7'h24 for 10 cycles after reset -> digits_o[6:0]=7'h24 and hex_o[3:0]=2 after edge E0+4; hex_valid_o[0]=1; other digits 7F with hex_valid 0.
2. Scan digits 0..3 with patterns 40,79,24,30, 8 cycles each -> hex_o=16'h3210, hex_valid_o=4'hF, exactly one frame_valid_o pulse one cycle after the digit-3 capture, seen cleared.
3. Digit 1 stable at 79, then sseg_i=7'h00 for 2 cycles, then back to 79 -> digits_o[13:7] stays 79 and no spurious capture occurs.
4. an_i=4'b1100 or 4'hF held 20 cycles with any sseg_i -> no capture and outputs unchanged; FSM stays in IDLE.
5. Scan only digits 0..2 for 100 cycles -> stale_o=4'b1000 at cycle 64 after reset release. Then drive digit 3 stable -> stale_o[3] drops the cycle after its capture.
6. Drop rst_ni low for 1 cycle at count=3 while digit 2 is settling on 7'h06 -> all outputs return to reset values. Capture of E (hex_o[11:8]=E) occurs 4 samples after reset release.
